// File: rtl/wb_csr_ctrl.sv
// Writeback-stage CSR / exception / ertn commit controller with flush-and-settle FSM.
// Optional debug trace outputs are enabled by defining WB_DEBUG_TRACE_EN.
module wb_csr_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [5:0]  ms_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wdata,
  input  logic [31:0] ms_csr_mask,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  output logic        csr_re,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  input  logic [31:0] csr_rvalue,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [31:0] wb_pc,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic        flush,
  output logic [31:0] flush_target,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_csr_blk
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`endif
);

  typedef enum logic {S_RUN = 1'b0, S_SETTLE = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [13:0] csr_num;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        irq;
  } ws_t;

  state_t state_q, state_d;
  logic   ws_valid_q, ws_valid_d;
  ws_t    ws_q, ws_d;

  logic op_ertn, op_sys, op_brk, op_xchg, op_wr, op_rd, op_csr, ws_exc, accept;

  always_comb begin
    op_ertn = ws_q.op[5];
    op_sys  = ws_q.op[4];
    op_brk  = ws_q.op[3];
    op_xchg = ws_q.op[2];
    op_wr   = ws_q.op[1];
    op_rd   = ws_q.op[0];
    op_csr  = op_rd | op_wr | op_xchg;
    ws_exc  = ws_q.irq | ws_q.ex | op_sys | op_brk;

    ws_allowin  = (state_q == S_RUN);
    wb_ex       = ws_valid_q & ws_exc;
    ertn_flush  = ws_valid_q & op_ertn & ~ws_exc;
    flush       = wb_ex | ertn_flush;
    flush_target = 32'h0;
    if (wb_ex)           flush_target = ex_entry;
    else if (ertn_flush) flush_target = ertn_entry;

    wb_pc       = ws_q.pc;
    wb_ecode    = 6'h0;
    wb_esubcode = 9'h0;
    if (ws_q.irq) begin
      wb_ecode = 6'h0;
    end else if (ws_q.ex) begin
      wb_ecode    = ws_q.ecode;
      wb_esubcode = ws_q.esubcode;
    end else if (op_sys) begin
      wb_ecode = 6'hB;
    end else if (op_brk) begin
      wb_ecode = 6'hC;
    end

    csr_re     = ws_valid_q & op_csr;
    csr_we     = ws_valid_q & (op_wr | op_xchg) & ~ws_exc;
    csr_num    = ws_q.csr_num;
    csr_wvalue = ws_q.wdata;
    csr_wmask  = 32'h0;
    if (op_wr)        csr_wmask = 32'hFFFF_FFFF;
    else if (op_xchg) csr_wmask = ws_q.mask;

    // CSR ops return the old CSR value to the GPR file
    rf_we      = ws_valid_q & ws_q.gr_we & ~ws_exc;
    rf_waddr   = ws_q.dest;
    rf_wdata   = op_csr ? csr_rvalue : ws_q.result;
    ws_csr_blk = ws_valid_q & (csr_we | op_ertn | ws_exc);
  end

  always_comb begin
    accept     = ms_to_ws_valid & ws_allowin & ~flush;
    ws_valid_d = flush ? 1'b0 : (ws_allowin ? ms_to_ws_valid : ws_valid_q);
    ws_d       = ws_q;
    if (accept) begin
      ws_d.pc       = ms_pc;
      ws_d.op       = ms_op;
      ws_d.csr_num  = ms_csr_num;
      ws_d.wdata    = ms_csr_wdata;
      ws_d.mask     = ms_csr_mask;
      ws_d.ex       = ms_ex;
      ws_d.ecode    = ms_ecode;
      ws_d.esubcode = ms_esubcode;
      ws_d.gr_we    = ms_gr_we;
      ws_d.dest     = ms_dest;
      ws_d.result   = ms_result;
      ws_d.irq      = has_int;
    end
    // Settle gives CRMD updates one cycle to reach has_int before the next accept
    state_d = state_q;
    case (state_q)
      S_RUN:    if (flush) state_d = S_SETTLE;
      S_SETTLE: state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      ws_valid_q <= 1'b0;
      ws_q       <= '0;
    end else begin
      state_q    <= state_d;
      ws_valid_q <= ws_valid_d;
      ws_q       <= ws_d;
    end
  end

`ifdef WB_DEBUG_TRACE_EN
  always_comb begin
    debug_wb_pc       = wb_pc;
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end
`endif

endmodule

// File: tb/tb_wb_csr_ctrl.sv
// Directed testbench for wb_csr_ctrl: CSR accesses, exceptions, ertn, flush/settle and reset.
module tb_wb_csr_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [5:0]  ms_op;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wdata, ms_csr_mask;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        csr_re, csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue, csr_rvalue;
  logic        has_int;
  logic [31:0] ex_entry, ertn_entry;
  logic        wb_ex, ertn_flush;
  logic [31:0] wb_pc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        flush;
  logic [31:0] flush_target;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_csr_blk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [5:0] OP_NONE = 6'b000000, OP_RD = 6'b000001, OP_WR = 6'b000010,
                         OP_XCHG = 6'b000100, OP_BRK = 6'b001000, OP_SYS = 6'b010000,
                         OP_ERTN = 6'b100000;

  wb_csr_ctrl dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_op(ms_op), .ms_csr_num(ms_csr_num), .ms_csr_wdata(ms_csr_wdata),
    .ms_csr_mask(ms_csr_mask), .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode),
    .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
    .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue), .has_int(has_int),
    .ex_entry(ex_entry), .ertn_entry(ertn_entry), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .wb_pc(wb_pc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .flush(flush),
    .flush_target(flush_target), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_csr_blk(ws_csr_blk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, take the accept edge, then drop valid.
  task automatic issue(input logic [5:0] op, input logic [31:0] pc, input logic [13:0] num,
                       input logic [31:0] wdata, input logic [31:0] mask, input logic ex,
                       input logic [5:0] ecode, input logic [8:0] esub, input logic gr_we,
                       input logic [4:0] dest, input logic [31:0] result);
    ms_to_ws_valid = 1'b1;
    ms_op = op; ms_pc = pc; ms_csr_num = num; ms_csr_wdata = wdata; ms_csr_mask = mask;
    ms_ex = ex; ms_ecode = ecode; ms_esubcode = esub;
    ms_gr_we = gr_we; ms_dest = dest; ms_result = result;
    step();
    ms_to_ws_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ms_to_ws_valid = 1'b0; ms_pc = '0; ms_op = '0; ms_csr_num = '0;
    ms_csr_wdata = '0; ms_csr_mask = '0; ms_ex = 1'b0; ms_ecode = '0; ms_esubcode = '0;
    ms_gr_we = 1'b0; ms_dest = '0; ms_result = '0; csr_rvalue = '0; has_int = 1'b0;
    ex_entry = 32'h1C00_8000; ertn_entry = 32'h1C00_0200;
    step(); step();

    chk("rst_allowin", ws_allowin, 1);
    chk("rst_flush", flush, 0);
    chk("rst_target", flush_target, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_csr_we", csr_we, 0);
    chk("rst_wb_ex", wb_ex, 0);
    chk("rst_ertn", ertn_flush, 0);
    chk("rst_wb_pc", wb_pc, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    reset = 1'b0;
    step();

    // csrrd
    issue(OP_RD, 32'h1C00_0000, 14'h30, 0, 0, 0, 0, 0, 1, 5, 32'hDEAD_0000);
    csr_rvalue = 32'h1234_5678;
    #1;
    chk("rd_csr_re", csr_re, 1);
    chk("rd_csr_we", csr_we, 0);
    chk("rd_csr_num", csr_num, 32'h30);
    chk("rd_rf_we", rf_we, 1);
    chk("rd_rf_waddr", rf_waddr, 5);
    chk("rd_rf_wdata", rf_wdata, 32'h1234_5678);
    chk("rd_blk", ws_csr_blk, 0);
    chk("rd_flush", flush, 0);

    // csrxchg
    issue(OP_XCHG, 32'h1C00_0004, 14'h5, 32'hAAAA_AAAA, 32'h0000_FF00, 0, 0, 0, 1, 7, 0);
    csr_rvalue = 32'h1111_1111;
    #1;
    chk("xchg_csr_we", csr_we, 1);
    chk("xchg_wmask", csr_wmask, 32'h0000_FF00);
    chk("xchg_wvalue", csr_wvalue, 32'hAAAA_AAAA);
    chk("xchg_rf_wdata", rf_wdata, 32'h1111_1111);
    chk("xchg_blk", ws_csr_blk, 1);

    // csrwr, with has_int rising after accept: the tag must not be applied late
    issue(OP_WR, 32'h1C00_0008, 14'h6, 32'h0BAD_F00D, 32'h1234_0000, 0, 0, 0, 1, 8, 0);
    has_int = 1'b1;
    #1;
    chk("wr_wmask", csr_wmask, 32'hFFFF_FFFF);
    chk("wr_csr_we", csr_we, 1);
    chk("wr_late_int", wb_ex, 0);
    has_int = 1'b0;

    // ordinary instruction
    issue(OP_NONE, 32'h1C00_000C, 14'h0, 0, 0, 0, 0, 0, 1, 3, 32'hCAFE_BABE);
    chk("alu_csr_re", csr_re, 0);
    chk("alu_rf_wdata", rf_wdata, 32'hCAFE_BABE);
    chk("alu_rf_we", rf_we, 1);
    step();
    chk("idle_rf_we", rf_we, 0);

    // syscall; a younger instruction sits in MEM during the flush cycle
    issue(OP_SYS, 32'h1C00_0100, 14'h0, 0, 0, 0, 0, 0, 1, 4, 32'h5555_5555);
    chk("sys_wb_ex", wb_ex, 1);
    chk("sys_ecode", wb_ecode, 32'hB);
    chk("sys_esub", wb_esubcode, 0);
    chk("sys_wb_pc", wb_pc, 32'h1C00_0100);
    chk("sys_flush", flush, 1);
    chk("sys_target", flush_target, 32'h1C00_8000);
    chk("sys_rf_we", rf_we, 0);
    chk("sys_ertn", ertn_flush, 0);
    issue(OP_NONE, 32'h1C00_0104, 14'h0, 0, 0, 0, 0, 0, 1, 9, 32'h7777_7777);
    chk("settle_allowin", ws_allowin, 0);
    chk("settle_flush", flush, 0);
    chk("settle_rf_we", rf_we, 0);
    step();
    chk("run_allowin", ws_allowin, 1);
    chk("run_rf_we", rf_we, 0);

    // upstream exception beats break
    issue(OP_BRK, 32'h1C00_0200, 14'h0, 0, 0, 1, 6'h8, 9'h1, 1, 2, 0);
    chk("adef_ecode", wb_ecode, 32'h8);
    chk("adef_esub", wb_esubcode, 32'h1);
    chk("adef_wb_ex", wb_ex, 1);
    step(); step();

    // break alone
    issue(OP_BRK, 32'h1C00_0300, 14'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("brk_ecode", wb_ecode, 32'hC);
    chk("brk_wb_ex", wb_ex, 1);
    step(); step();

    // csrwr taking an interrupt
    has_int = 1'b1;
    issue(OP_WR, 32'h1C00_0400, 14'h1, 32'h1, 0, 0, 0, 0, 1, 6, 0);
    has_int = 1'b0;
    #1;
    chk("int_ecode", wb_ecode, 32'h0);
    chk("int_wb_ex", wb_ex, 1);
    chk("int_csr_we", csr_we, 0);
    chk("int_rf_we", rf_we, 0);
    chk("int_flush", flush, 1);
    step(); step();
    issue(OP_WR, 32'h1C00_0404, 14'h1, 32'h1, 0, 0, 0, 0, 1, 6, 0);
    chk("post_int_csr_we", csr_we, 1);
    chk("post_int_wb_ex", wb_ex, 0);
    chk("post_int_rf_we", rf_we, 1);

    // ertn; the MEM instruction valid in the flush cycle must be dropped
    ex_entry = 32'h1C00_9000;
    issue(OP_ERTN, 32'h1C00_0500, 14'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ertn_flush", ertn_flush, 1);
    chk("ertn_wb_ex", wb_ex, 0);
    chk("ertn_target", flush_target, 32'h1C00_0200);
    chk("ertn_blk", ws_csr_blk, 1);
    issue(OP_NONE, 32'h1C00_0504, 14'h0, 0, 0, 0, 0, 0, 1, 10, 32'h8888_8888);
    chk("ertn_drop_rf_we", rf_we, 0);
    step();
    chk("ertn_drop2_rf_we", rf_we, 0);

    // exception together with ertn: exception wins
    issue(OP_ERTN, 32'h1C00_0600, 14'h0, 0, 0, 1, 6'hD, 9'h0, 0, 0, 0);
    chk("exertn_wb_ex", wb_ex, 1);
    chk("exertn_ertn", ertn_flush, 0);
    chk("exertn_target", flush_target, 32'h1C00_9000);
    chk("exertn_ecode", wb_ecode, 32'hD);

    // reset asserted during settle
    step();
    chk("pre_rst_allowin", ws_allowin, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_settle_allowin", ws_allowin, 1);
    chk("rst_settle_flush", flush, 0);
    chk("rst_settle_rf_we", rf_we, 0);

    // reset asserted in a flush cycle
    issue(OP_SYS, 32'h1C00_0700, 14'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_flush", flush, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_flush_allowin", ws_allowin, 1);
    chk("rst_flush_flush", flush, 0);
    chk("rst_flush_wb_ex", wb_ex, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
